// File: rtl/turbosound_pkg.sv
// Shared types, port constants and stereo weight table for the TurboSound PSG block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package turbosound_pkg;

    typedef enum logic [1:0] {
        SM_ABC      = 2'd0,
        SM_ACB      = 2'd1,
        SM_MONO     = 2'd2,
        SM_MONO_ALT = 2'd3
    } stereo_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CE = 2'd1,
        STROBE  = 2'd2,
        HOLD    = 2'd3
    } wr_state_t;

    localparam logic [15:0] PORT_REG = 16'hFFFD;
    localparam logic [15:0] PORT_DAT = 16'hBFFD;
    localparam logic [7:0]  SEL_BASE = 8'hFC;

    // Weight rows hold channel A in [1:0], B in [3:2], C in [5:4]; value is 0, 1 or 2.
    localparam logic [5:0] WT_ABC_L = {2'd0, 2'd1, 2'd2};
    localparam logic [5:0] WT_ABC_R = {2'd2, 2'd1, 2'd0};
    localparam logic [5:0] WT_ACB_L = {2'd1, 2'd0, 2'd2};
    localparam logic [5:0] WT_ACB_R = {2'd1, 2'd2, 2'd0};
    localparam logic [5:0] WT_MONO  = {2'd1, 2'd1, 2'd1};

    function automatic logic [1:0] mix_weight(input logic [1:0] mode, input logic [1:0] ch,
                                              input logic right);
        logic [5:0] row;
        case (stereo_mode_t'(mode))
            SM_ABC:  row = right ? WT_ABC_R : WT_ABC_L;
            SM_ACB:  row = right ? WT_ACB_R : WT_ACB_L;
            default: row = WT_MONO;
        endcase
        return row[2*ch +: 2];
    endfunction

endpackage

// File: rtl/turbosound_bus_mix_mix_acc.sv
// Time-multiplexed weighted L/R accumulator over all PSG channels, one channel per cycle.
// Latency: inputs snapshotted at slot 0, published 3*NUM_PSG+1 cycles later with sample_stb.
// Backpressure: none; free-running, consumers must take each sample on sample_stb.
module psg_mix_acc
    import turbosound_pkg::*;
#(
    parameter int NUM_PSG = 2,
    parameter int CH_W    = 8,
    parameter int OUT_W   = 12
) (
    input  logic                        CLK,
    input  logic                        nRESET,
    input  logic [1:0]                  stereo_mode,
    input  logic [NUM_PSG*3*CH_W-1:0]   ch_in,
    output logic [OUT_W-1:0]            audio_l,
    output logic [OUT_W-1:0]            audio_r,
    output logic                        sample_stb
);

    localparam int NCH = 3 * NUM_PSG;
    localparam int SW  = $clog2(NCH + 1);

    logic [SW-1:0]              slot;
    logic [SW-1:0]              ch_idx;
    logic [NCH-1:0][CH_W-1:0]   snap;
    logic [1:0]                 mode_q;
    logic [1:0]                 ch_c;
    logic [OUT_W-1:0]           acc_l;
    logic [OUT_W-1:0]           acc_r;
    logic [OUT_W-1:0]           ext;
    logic [OUT_W-1:0]           term_l;
    logic [OUT_W-1:0]           term_r;
    logic [1:0]                 wl;
    logic [1:0]                 wr;

    assign ch_idx = slot - SW'(1);
    assign ext    = OUT_W'(snap[ch_idx]);
    assign wl     = mix_weight(mode_q, ch_c, 1'b0);
    assign wr     = mix_weight(mode_q, ch_c, 1'b1);
    assign term_l = (wl == 2'd2) ? (ext << 1) : ((wl == 2'd1) ? ext : '0);
    assign term_r = (wr == 2'd2) ? (ext << 1) : ((wr == 2'd1) ? ext : '0);

    // Slot 0 both publishes the finished sweep and starts the next one.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            slot       <= '0;
            snap       <= '0;
            mode_q     <= '0;
            ch_c       <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            audio_l    <= '0;
            audio_r    <= '0;
            sample_stb <= 1'b0;
        end else begin
            slot <= (slot == SW'(NCH)) ? '0 : slot + SW'(1);
            if (slot == '0) begin
                snap       <= ch_in;
                mode_q     <= stereo_mode;
                ch_c       <= '0;
                acc_l      <= '0;
                acc_r      <= '0;
                audio_l    <= acc_l;
                audio_r    <= acc_r;
                sample_stb <= 1'b1;
            end else begin
                acc_l      <= acc_l + term_l;
                acc_r      <= acc_r + term_r;
                ch_c       <= (ch_c == 2'd2) ? 2'd0 : ch_c + 2'd1;
                sample_stb <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/turbosound_bus_mix.sv
// Spectrum 128 PSG port decode, TurboSound chip select, per-chip write strobes, read mux and stereo mix.
// Latency: read data 1 CLK; write strobe starts the CLK after the first cpu_ce of the bus cycle.
// Backpressure: none; the CPU bus is never stalled, writes arriving mid-strobe are absorbed by HOLD.
module turbosound_bus_mix
    import turbosound_pkg::*;
#(
    parameter int NUM_PSG    = 2,
    parameter int CH_W       = 8,
    parameter int OUT_W      = 12,
    parameter int STROBE_LEN = 4
) (
    input  logic                        CLK,
    input  logic                        nRESET,
    input  logic [15:0]                 addr,
    input  logic [7:0]                  din,
    input  logic                        nIORQ,
    input  logic                        nM1,
    input  logic                        nRD,
    input  logic                        nWR,
    input  logic                        cpu_ce,
    input  logic [1:0]                  stereo_mode,
    input  logic [NUM_PSG*8-1:0]        psg_do,
    input  logic [NUM_PSG*3*CH_W-1:0]   ch_in,
    output logic [NUM_PSG-1:0]          psg_bdir,
    output logic                        psg_bc,
    output logic [7:0]                  psg_di,
    output logic [7:0]                  dout,
    output logic [1:0]                  sel,
    output logic [OUT_W-1:0]            audio_l,
    output logic [OUT_W-1:0]            audio_r,
    output logic                        sample_stb
);

    localparam int SCW = $clog2(STROBE_LEN) + 1;

    logic               hit;
    logic               wr;
    logic               rd;
    logic               sel_cmd;
    logic               fwd_wr;
    logic [7:0]         sel_idx;
    logic [7:0]         rd_mux;
    logic               latch_en;
    logic [1:0]         strobe_sel;
    logic [SCW-1:0]     strobe_cnt;
    wr_state_t          state;
    wr_state_t          state_nxt;
    logic               unused_addr;

    assign unused_addr = ^addr[13:2];

    assign hit     = addr[15] & ~addr[1] & addr[0] & ~nIORQ & nM1;
    assign wr      = hit & ~nWR;
    assign rd      = hit & ~nRD;
    assign sel_cmd = wr & addr[14] & (din >= SEL_BASE);
    assign fwd_wr  = wr & ~sel_cmd;
    assign sel_idx = 8'hFF - din;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sel <= '0;
        end else if (sel_cmd && (sel_idx < 8'(NUM_PSG))) begin
            sel <= sel_idx[1:0];
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // HOLD absorbs extra cpu_ce pulses so one bus cycle yields one strobe.
    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        case (state)
            IDLE:    if (fwd_wr) state_nxt = WAIT_CE;
            WAIT_CE: begin
                if (!fwd_wr) begin
                    state_nxt = IDLE;
                end else if (cpu_ce) begin
                    latch_en  = 1'b1;
                    state_nxt = STROBE;
                end
            end
            STROBE:  if (strobe_cnt == SCW'(STROBE_LEN - 1)) state_nxt = HOLD;
            HOLD:    if (!wr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            psg_di     <= '0;
            psg_bc     <= 1'b0;
            strobe_sel <= '0;
            strobe_cnt <= '0;
        end else if (latch_en) begin
            psg_di     <= din;
            psg_bc     <= addr[14];
            strobe_sel <= sel;
            strobe_cnt <= '0;
        end else if (state == STROBE) begin
            strobe_cnt <= strobe_cnt + SCW'(1);
        end
    end

    always_comb begin
        psg_bdir = '0;
        for (int i = 0; i < NUM_PSG; i++) begin
            psg_bdir[i] = (state == STROBE) && (strobe_sel == 2'(i));
        end
    end

    always_comb begin
        rd_mux = 8'hFF;
        for (int i = 0; i < NUM_PSG; i++) begin
            if (sel == 2'(i)) rd_mux = psg_do[8*i +: 8];
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            dout <= 8'hFF;
        end else begin
            dout <= (rd && addr[14]) ? rd_mux : 8'hFF;
        end
    end

    psg_mix_acc #(
        .NUM_PSG (NUM_PSG),
        .CH_W    (CH_W),
        .OUT_W   (OUT_W)
    ) u_mix (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .stereo_mode (stereo_mode),
        .ch_in       (ch_in),
        .audio_l     (audio_l),
        .audio_r     (audio_r),
        .sample_stb  (sample_stb)
    );

endmodule

// File: tb/tb_turbosound_bus_mix.sv
// Bench for turbosound_bus_mix: directed and random bus cycles plus mixer sweeps against a reference model.
module tb_turbosound_bus_mix;
    import turbosound_pkg::*;

    localparam int NUM_PSG    = 2;
    localparam int CH_W       = 8;
    localparam int OUT_W      = 12;
    localparam int STROBE_LEN = 4;

    logic                       CLK = 1'b0;
    logic                       nRESET;
    logic [15:0]                addr;
    logic [7:0]                 din;
    logic                       nIORQ, nM1, nRD, nWR, cpu_ce;
    logic [1:0]                 stereo_mode;
    logic [NUM_PSG*8-1:0]       psg_do;
    logic [NUM_PSG*3*CH_W-1:0]  ch_in;
    logic [NUM_PSG-1:0]         psg_bdir;
    logic                       psg_bc;
    logic [7:0]                 psg_di;
    logic [7:0]                 dout;
    logic [1:0]                 sel;
    logic [OUT_W-1:0]           audio_l, audio_r;
    logic                       sample_stb;

    turbosound_bus_mix #(
        .NUM_PSG(NUM_PSG), .CH_W(CH_W), .OUT_W(OUT_W), .STROBE_LEN(STROBE_LEN)
    ) dut (
        .CLK(CLK), .nRESET(nRESET), .addr(addr), .din(din), .nIORQ(nIORQ), .nM1(nM1),
        .nRD(nRD), .nWR(nWR), .cpu_ce(cpu_ce), .stereo_mode(stereo_mode), .psg_do(psg_do),
        .ch_in(ch_in), .psg_bdir(psg_bdir), .psg_bc(psg_bc), .psg_di(psg_di), .dout(dout),
        .sel(sel), .audio_l(audio_l), .audio_r(audio_r), .sample_stb(sample_stb)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference state: current chip select and expected strobe totals per chip.
    int          model_sel;
    int          exp_pulses [NUM_PSG];
    int          exp_cyc    [NUM_PSG];
    logic [7:0]  exp_di;
    logic        exp_bc;
    bit          exp_new;

    int          mon_pulses [NUM_PSG];
    int          mon_cyc    [NUM_PSG];
    logic [7:0]  mon_di;
    logic        mon_bc;
    logic [NUM_PSG-1:0] prev_bdir;
    bit          mon_clr = 1'b0;

    // Channel weights per mode row (ABC, ACB, mono) and channel column (A, B, C).
    int WL [3][3] = '{'{2, 1, 0}, '{2, 0, 1}, '{1, 1, 1}};
    int WR [3][3] = '{'{0, 1, 2}, '{0, 2, 1}, '{1, 1, 1}};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_clr) begin
            for (int i = 0; i < NUM_PSG; i++) begin
                mon_pulses[i] = 0;
                mon_cyc[i]    = 0;
            end
            prev_bdir = '0;
        end else begin
            for (int i = 0; i < NUM_PSG; i++) begin
                if (psg_bdir[i]) begin
                    mon_cyc[i]++;
                    if (!prev_bdir[i]) begin
                        mon_pulses[i]++;
                        mon_di = psg_di;
                        mon_bc = psg_bc;
                    end
                end
            end
            prev_bdir = psg_bdir;
        end
    end

    task automatic clear_counts();
        mon_clr = 1'b1;
        @(negedge CLK);
        #1 mon_clr = 1'b0;
        for (int i = 0; i < NUM_PSG; i++) begin
            exp_pulses[i] = 0;
            exp_cyc[i]    = 0;
        end
        exp_new = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int len,
                             input bit ce_en, input logic m1);
        int idx;
        @(posedge CLK);
        #1;
        addr = a; din = d; nM1 = m1; nIORQ = 1'b0; nWR = 1'b0;
        for (int k = 0; k < len; k++) begin
            cpu_ce = ce_en && (k % 4 == 2);
            @(posedge CLK);
            #1;
        end
        cpu_ce = 1'b0; nIORQ = 1'b1; nWR = 1'b1; nM1 = 1'b1; addr = 16'h0000;
        exp_new = 1'b0;
        if (a[15] && !a[1] && a[0] && m1) begin
            if (a[14] && d >= 8'hFC) begin
                idx = 255 - int'(d);
                if (idx < NUM_PSG) model_sel = idx;
            end else if (ce_en) begin
                exp_pulses[model_sel]++;
                exp_cyc[model_sel] += STROBE_LEN;
                exp_di  = d;
                exp_bc  = a[14];
                exp_new = 1'b1;
            end
        end
    endtask

    task automatic settle_check();
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        for (int i = 0; i < NUM_PSG; i++) begin
            check_eq($sformatf("strobe_pulses%0d", i), mon_pulses[i], exp_pulses[i]);
            check_eq($sformatf("strobe_cycles%0d", i), mon_cyc[i], exp_cyc[i]);
        end
        if (exp_new) begin
            check_eq("psg_di", mon_di, exp_di);
            check_eq("psg_bc", mon_bc, exp_bc);
        end
        check_eq("sel", sel, model_sel);
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [NUM_PSG*8-1:0] pdo);
        logic [7:0] exp;
        @(posedge CLK);
        #1;
        psg_do = pdo; addr = a; nIORQ = 1'b0; nRD = 1'b0;
        exp = a[14] ? pdo[8*model_sel +: 8] : 8'hFF;
        @(posedge CLK);
        @(negedge CLK);
        check_eq($sformatf("rd_%0h", a), dout, exp);
        #1;
        @(posedge CLK);
        #1;
        nIORQ = 1'b1; nRD = 1'b1; addr = 16'h0000;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("rd_idle", dout, 8'hFF);
    endtask

    task automatic wait_stb(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!sample_stb && n < 64);
        if (!sample_stb) check_eq("stb_timeout", sample_stb, 1);
    endtask

    task automatic mix_model(input logic [1:0] m, output int l, output int r);
        int mi;
        int v;
        mi = (m >= 2) ? 2 : int'(m);
        l = 0;
        r = 0;
        for (int chip = 0; chip < NUM_PSG; chip++) begin
            for (int c = 0; c < 3; c++) begin
                v = int'(ch_in[(3*chip + c)*CH_W +: CH_W]);
                l += v * WL[mi][c];
                r += v * WR[mi][c];
            end
        end
    endtask

    task automatic mix_check(input string tag, input logic [1:0] m);
        int n, l, r;
        @(posedge CLK);
        #1 stereo_mode = m;
        wait_stb(n);
        wait_stb(n);
        mix_model(m, l, r);
        check_eq({tag, "_l"}, audio_l, l);
        check_eq({tag, "_r"}, audio_r, r);
        wait_stb(n);
        check_eq({tag, "_period"}, n, 3*NUM_PSG + 1);
    endtask

    logic [15:0] non_hit [3] = '{16'h7FFD, 16'hFFFF, 16'hFFFC};

    initial begin
        int kind, n, l, r, l_old, r_old;
        nRESET = 1'b0; addr = '0; din = '0; nIORQ = 1'b1; nM1 = 1'b1; nRD = 1'b1; nWR = 1'b1;
        cpu_ce = 1'b0; stereo_mode = 2'd0; psg_do = '0; ch_in = '0; model_sel = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_bdir", psg_bdir, 0);
        check_eq("rst_dout", dout, 8'hFF);
        check_eq("rst_sel", sel, 0);
        check_eq("rst_di", psg_di, 0);
        check_eq("rst_bc", psg_bc, 0);
        check_eq("rst_audio", {audio_l, audio_r}, 0);
        check_eq("rst_stb", sample_stb, 0);
        #1 nRESET = 1'b1;
        clear_counts();

        // Select chip 1, then data write to it.
        bus_write(PORT_REG, 8'hFE, 4, 1'b1, 1'b1);  settle_check();
        bus_write(PORT_DAT, 8'h3C, 6, 1'b1, 1'b1);  settle_check();
        // Out-of-range select ignored; non-select value on FFFD is a register write.
        bus_write(PORT_REG, 8'hFD, 4, 1'b1, 1'b1);  settle_check();
        bus_write(PORT_REG, 8'h07, 6, 1'b1, 1'b1);  settle_check();
        bus_read(PORT_REG, {8'hA5, 8'h11});
        bus_read(PORT_DAT, {8'hA5, 8'h11});
        // Five cpu_ce pulses in one cycle, then an aborted write.
        bus_write(PORT_DAT, 8'h5A, 20, 1'b1, 1'b1); settle_check();
        bus_write(PORT_DAT, 8'h66, 10, 1'b0, 1'b1); settle_check();
        // Select change while chip 1 is still strobing.
        bus_write(PORT_DAT, 8'h55, 3, 1'b1, 1'b1);
        bus_write(PORT_REG, 8'hFF, 3, 1'b1, 1'b1);  settle_check();
        bus_write(PORT_DAT, 8'h99, 5, 1'b1, 1'b0);  settle_check();

        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: bus_write($urandom_range(0, 1) ? PORT_REG : PORT_DAT, 8'($urandom),
                                $urandom_range(3, 20), $urandom_range(0, 3) != 0, 1'b1);
                2:    bus_write(PORT_REG, 8'($urandom_range(252, 255)), $urandom_range(3, 8),
                                1'b1, 1'b1);
                3:    bus_write(non_hit[$urandom_range(0, 2)], 8'($urandom), 6, 1'b1, 1'b1);
                default: bus_read($urandom_range(0, 1) ? PORT_REG : PORT_DAT, 16'($urandom));
            endcase
            if (kind <= 3) settle_check();
        end

        // Mixer: chip0 A=100 B=50 C=10, chip1 silent.
        ch_in = '0;
        ch_in[0*CH_W +: CH_W] = 8'd100;
        ch_in[1*CH_W +: CH_W] = 8'd50;
        ch_in[2*CH_W +: CH_W] = 8'd10;
        mix_check("abc", 2'd0);
        check_eq("abc_l_const", audio_l, 250);
        mix_check("acb", 2'd1);
        mix_check("mono", 2'd2);
        mix_check("mono3", 2'd3);

        // Mode change mid-sweep only lands at the next snapshot.
        mix_check("pre_mid", 2'd0);
        mix_model(2'd0, l_old, r_old);
        @(posedge CLK);
        #1 stereo_mode = 2'd1;
        wait_stb(n);
        check_eq("mid_old_l", audio_l, l_old);
        check_eq("mid_old_r", audio_r, r_old);
        wait_stb(n);
        mix_model(2'd1, l, r);
        check_eq("mid_new_l", audio_l, l);
        check_eq("mid_new_r", audio_r, r);

        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 3*NUM_PSG; k++) ch_in[k*CH_W +: CH_W] = CH_W'($urandom_range(0, 255));
            mix_check("rand_mix", 2'($urandom_range(0, 3)));
        end

        // Async reset in the middle of a strobe.
        @(posedge CLK);
        #1 addr = PORT_DAT; din = 8'h42; nIORQ = 1'b0; nWR = 1'b0;
        @(posedge CLK);
        #1 cpu_ce = 1'b1;
        @(posedge CLK);
        #1 cpu_ce = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("pre_rst_strobe", psg_bdir != 0, 1);
        #2 nRESET = 1'b0;
        #1;
        check_eq("mid_rst_bdir", psg_bdir, 0);
        check_eq("mid_rst_dout", dout, 8'hFF);
        check_eq("mid_rst_sel", sel, 0);
        nIORQ = 1'b1; nWR = 1'b1; addr = 16'h0000;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRESET = 1'b1;
        model_sel = 0;
        clear_counts();
        bus_write(PORT_DAT, 8'hC3, 6, 1'b1, 1'b1);  settle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
